// File: rtl/m2_pkg.sv
// Shared definitions for the m2 Manchester-II link (encode_m2 / decode_m2).
package m2_pkg;

  localparam int unsigned WORD_W       = 16;
  localparam int unsigned FRAME_CHIPS  = 34;
  localparam int unsigned CHIP_CYC_DEF = 289;
  localparam int unsigned SYNC_CHIPS   = 3;
  localparam int unsigned GAP_CHIPS    = 2;
  localparam int unsigned IDX_W        = 6;

  // One-hot transmitter states
  localparam logic [3:0] IDLE = 4'b0001;
  localparam logic [3:0] SYNC = 4'b0010;
  localparam logic [3:0] DATA = 4'b0100;
  localparam logic [3:0] GAP  = 4'b1000;

  // Builds the 34-chip frame body: {d15,~d15, ..., d0,~d0, trailer}, MSB sent first
  function automatic logic [FRAME_CHIPS-1:0] m2_frame_chips(input logic [WORD_W-1:0] data,
                                                            input logic [1:0]        trailer);
    logic [FRAME_CHIPS-1:0] chips;
    chips = '0;
    for (int i = 0; i < int'(WORD_W); i++) begin
      chips[2*i+3] = data[i];
      chips[2*i+2] = ~data[i];
    end
    chips[1:0] = trailer;
    return chips;
  endfunction

endpackage

// File: rtl/m2_chip_timer.sv
// Chip-period timer: counts 0..CHIP_CYC-1 and flags the last cycle of each chip.
module m2_chip_timer
  import m2_pkg::*;
#(
  parameter int unsigned CHIP_CYC = CHIP_CYC_DEF
) (
  input  logic clock_system,
  input  logic rstn,
  input  logic clr,
  output logic chip_tick
);

  localparam int unsigned CNT_W = (CHIP_CYC > 1) ? $clog2(CHIP_CYC) : 1;

  logic [CNT_W-1:0] chip_cnt;

  // Chip counter, held at zero while clr so the first chip starts aligned
  always_ff @(posedge clock_system) begin
    if (!rstn || clr) begin
      chip_cnt <= '0;
    end else if (chip_cnt == CNT_W'(CHIP_CYC - 1)) begin
      chip_cnt <= '0;
    end else begin
      chip_cnt <= chip_cnt + CNT_W'(1);
    end
  end

  assign chip_tick = (chip_cnt == CNT_W'(CHIP_CYC - 1));

endmodule

// File: rtl/encode_m2.sv
// Manchester-II serial transmitter for the m2 link.
// Frame: SYNC_CHIPS high chips, 34 data/trailer chips, GAP_CHIPS low chips.
// Optional build macro M2_ODD_PARITY_EN: trailer carries odd parity {p,~p}
// instead of the fixed {0,1}.
module encode_m2
  import m2_pkg::*;
#(
  parameter int unsigned CHIP_CYC = CHIP_CYC_DEF
) (
  input  logic              clock_system,
  input  logic              rstn,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              m2_udo,
  output logic              tx_busy,
  output logic              tx_done
);

  logic [3:0]             state, state_d;
  logic [FRAME_CHIPS-1:0] shreg, shreg_d;
  logic [IDX_W-1:0]       chip_idx, chip_idx_d;
  logic                   m2_udo_d, tx_ready_d, tx_busy_d, tx_done_d;
  logic                   chip_tick;
  logic                   timer_clr;
  logic [1:0]             trailer;

`ifdef M2_ODD_PARITY_EN
  assign trailer = {~^tx_data, ^tx_data};
`else
  assign trailer = 2'b01;
`endif

  // Timer idles at zero so chip 0 of SYNC begins right on the accept edge
  assign timer_clr = (state == IDLE);

  m2_chip_timer #(
    .CHIP_CYC (CHIP_CYC)
  ) u_chip_timer (
    .clock_system (clock_system),
    .rstn         (rstn),
    .clr          (timer_clr),
    .chip_tick    (chip_tick)
  );

  // State and output registers; the line is driven straight from a flop
  always_ff @(posedge clock_system) begin
    if (!rstn) begin
      state    <= IDLE;
      shreg    <= '0;
      chip_idx <= '0;
      m2_udo   <= 1'b0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      chip_idx <= chip_idx_d;
      m2_udo   <= m2_udo_d;
      tx_ready <= tx_ready_d;
      tx_busy  <= tx_busy_d;
      tx_done  <= tx_done_d;
    end
  end

  // Next-state, shift register, chip index and registered-output inputs
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    chip_idx_d = chip_idx;
    tx_done_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d    = SYNC;
          shreg_d    = m2_frame_chips(tx_data, trailer);
          chip_idx_d = '0;
        end
      end
      SYNC: begin
        if (chip_tick) begin
          if (chip_idx == IDX_W'(SYNC_CHIPS - 1)) begin
            state_d    = DATA;
            chip_idx_d = '0;
          end else begin
            chip_idx_d = chip_idx + IDX_W'(1);
          end
        end
      end
      DATA: begin
        if (chip_tick) begin
          shreg_d = {shreg[FRAME_CHIPS-2:0], 1'b0};
          if (chip_idx == IDX_W'(FRAME_CHIPS - 1)) begin
            state_d    = GAP;
            chip_idx_d = '0;
          end else begin
            chip_idx_d = chip_idx + IDX_W'(1);
          end
        end
      end
      GAP: begin
        if (chip_tick) begin
          if (chip_idx == IDX_W'(GAP_CHIPS - 1)) begin
            state_d    = IDLE;
            chip_idx_d = '0;
            tx_done_d  = 1'b1;
          end else begin
            chip_idx_d = chip_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d    = IDLE;
        chip_idx_d = '0;
      end
    endcase

    // Line follows the current state, so it appears one cycle after the state change
    m2_udo_d   = (state == SYNC) || ((state == DATA) && shreg[FRAME_CHIPS-1]);
    tx_ready_d = (state_d == IDLE);
    tx_busy_d  = (state_d != IDLE);
  end

endmodule
